// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB stepping, memory
// handshakes with timeout, datapath enable pulses and PC ownership.
module instr_sequencer #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned PC_STEP     = 4,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  output logic [5:0]          opcode,
  input  logic [1:0]          reg_write,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [1:0]          branch,
  input  logic [1:0]          mem_to_reg,
  input  logic [2:0]          alu_op,
  input  logic                alu_src,
  input  logic                cond_true,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic                alu_en,
  output logic [2:0]          alu_op_q,
  output logic                alu_src_q,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  output logic [1:0]          rf_we,
  output logic [1:0]          wb_sel,
  output logic [PC_WIDTH-1:0] pc,
  output logic                halted,
  output logic                error
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERROR
  } state_t;

  state_t              state, state_nxt;
  logic [7:0]          tmo_cnt;
  logic                tmo_hit;
  logic [1:0]          reg_write_q, branch_q;
  logic                mem_read_q, mem_write_q, cond_q;
  logic [PC_WIDTH-1:0] target_q, pc_seq, pc_nxt;
  logic                unused_rdata;

  assign unused_rdata = ^imem_rdata[25:0];
  assign tmo_hit      = (tmo_cnt == 8'(MEM_TIMEOUT));
  assign pc_seq       = pc + PC_WIDTH'(PC_STEP);

  always_comb begin
    unique case (branch_q)
      2'b00:   pc_nxt = pc_seq;
      2'b01:   pc_nxt = cond_q ? target_q : pc_seq;
      default: pc_nxt = target_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Outputs decode from state alone so an async reset drops every request at once.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    alu_en    = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = '0;
    halted    = 1'b0;
    error     = 1'b0;
    unique case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)     state_nxt = S_DECODE;
        else if (tmo_hit) state_nxt = S_ERROR;
      end
      S_DECODE: state_nxt = (opcode == HALT_OPCODE) ? S_HALT : S_EXEC;
      S_EXEC: begin
        alu_en    = 1'b1;
        state_nxt = (mem_read_q || mem_write_q) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = mem_write_q;
        if (dmem_ack)     state_nxt = S_WB;
        else if (tmo_hit) state_nxt = S_ERROR;
      end
      S_WB: begin
        rf_we     = reg_write_q;
        state_nxt = S_FETCH;
      end
      S_HALT:   halted = 1'b1;
      S_ERROR:  error  = 1'b1;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Counter idles at zero outside the wait states, so each FETCH/MEM entry starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt     <= '0;
      opcode      <= '0;
      reg_write_q <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= '0;
      wb_sel      <= '0;
      alu_op_q    <= '0;
      alu_src_q   <= 1'b0;
      cond_q      <= 1'b0;
      target_q    <= '0;
      pc          <= '0;
    end else begin
      tmo_cnt <= (state == S_FETCH || state == S_MEM) ? tmo_cnt + 8'd1 : '0;
      unique case (state)
        S_FETCH:  if (imem_ack) opcode <= imem_rdata[31:26];
        S_DECODE: if (opcode != HALT_OPCODE) begin
          reg_write_q <= reg_write;
          mem_read_q  <= mem_read;
          mem_write_q <= mem_write;
          branch_q    <= branch;
          wb_sel      <= mem_to_reg;
          alu_op_q    <= alu_op;
          alu_src_q   <= alu_src;
        end
        S_EXEC: begin
          cond_q   <= cond_true;
          target_q <= branch_target;
        end
        S_WB:     pc <= pc_nxt;
        default:  ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed scenarios plus randomized instruction streams
// checked against an instruction-level model of PC flow and per-phase outputs.
module tb_instr_sequencer;
  localparam int unsigned TMO  = 15;
  localparam logic [5:0]  HALT = 6'b111111;

  typedef struct packed {
    logic [1:0] rw;
    logic       mr;
    logic       mw;
    logic [1:0] br;
    logic [1:0] m2r;
    logic [2:0] aop;
    logic       asrc;
  } ctrl_t;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic        imem_req, imem_ack = 1'b0, dmem_req, dmem_we, dmem_ack = 1'b0;
  logic [31:0] imem_rdata = '0, branch_target = '0, pc;
  logic [5:0]  opcode;
  logic        cond_true = 1'b0, alu_en, alu_src_q, halted, error;
  logic [2:0]  alu_op_q;
  logic [1:0]  rf_we, wb_sel;
  ctrl_t       dec;
  int          tests = 0, fails = 0;
  logic [31:0] exp_pc = '0;
  logic [5:0]  ops [7] = '{6'b000000, 6'b000101, 6'b000110, 6'b000111,
                           6'b000011, 6'b001000, 6'b001001};

  function automatic ctrl_t decode(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      6'b000000: begin c.rw = 2'b10; c.aop = 3'b010; end
      6'b000101: begin c.mr = 1'b1; c.m2r = 2'b01; c.rw = 2'b10; c.asrc = 1'b1; end
      6'b000110: begin c.mw = 1'b1; c.asrc = 1'b1; end
      6'b000111: begin c.mr = 1'b1; c.mw = 1'b1; c.asrc = 1'b1; c.aop = 3'b011; end
      6'b000011: begin c.br = 2'b01; c.aop = 3'b001; end
      6'b001000: c.br = 2'b10;
      6'b001001: begin c.br = 2'b11; c.rw = 2'b01; c.m2r = 2'b10; c.aop = 3'b100; end
      HALT:      c = '1;
      default:   c = '0;
    endcase
    return c;
  endfunction

  always_comb dec = decode(opcode);
  always #5 clk = ~clk;

  instr_sequencer #(.PC_WIDTH(32), .PC_STEP(4), .MEM_TIMEOUT(TMO), .HALT_OPCODE(HALT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .opcode(opcode),
    .reg_write(dec.rw), .mem_read(dec.mr), .mem_write(dec.mw), .branch(dec.br),
    .mem_to_reg(dec.m2r), .alu_op(dec.aop), .alu_src(dec.asrc),
    .cond_true(cond_true), .branch_target(branch_target),
    .alu_en(alu_en), .alu_op_q(alu_op_q), .alu_src_q(alu_src_q),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .rf_we(rf_we), .wb_sel(wb_sel), .pc(pc), .halted(halted), .error(error)
  );

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(negedge clk);
    tests++;
    if ({imem_req, dmem_req, alu_en, rf_we, halted, error} !== 7'b0 ||
        pc !== 32'h0 || opcode !== 6'h0 || alu_op_q !== 3'h0 || wb_sel !== 2'h0) begin
      fails++;
      $display("FAIL reset_state: req/en/flags=%b pc=%h opcode=%h aop=%h wb_sel=%h, all expected 0",
               {imem_req, dmem_req, alu_en, rf_we, halted, error}, pc, opcode, alu_op_q, wb_sel);
    end
    rst_n = 1'b1;
    exp_pc = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (imem_req !== 1'b0) begin
        fails++; $display("FAIL idle_quiet: imem_req=%b expected 0", imem_req);
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered at a negedge in FETCH; leaves at the negedge of the following FETCH (or in HALT).
  task automatic run_instr(input logic [5:0] op, input int unsigned fdly, input int unsigned mdly,
                           input logic cnd, input logic [31:0] tgt);
    ctrl_t c;
    c = decode(op);
    for (int unsigned i = 0; i <= fdly; i++) begin
      tests++;
      if (imem_req !== 1'b1) begin
        fails++; $display("FAIL fetch_req: cycle %0d imem_req=%b expected 1", i, imem_req);
      end
      imem_rdata = {op, 26'($urandom)};
      imem_ack   = (i == fdly);
      @(negedge clk);
    end
    imem_ack = 1'b0; imem_rdata = $urandom;
    tests++;
    if (opcode !== op || imem_req !== 1'b0 || alu_en !== 1'b0 || rf_we !== 2'b00 || error !== 1'b0) begin
      fails++;
      $display("FAIL decode_phase: opcode=%h req=%b alu_en=%b rf_we=%b err=%b expected opcode=%h rest 0",
               opcode, imem_req, alu_en, rf_we, error, op);
    end
    cond_true = cnd; branch_target = tgt;
    @(negedge clk);
    if (op == HALT) begin
      for (int i = 0; i < 5; i++) begin
        tests++;
        if (halted !== 1'b1 || pc !== exp_pc || {imem_req, alu_en, dmem_req, rf_we} !== 5'b0) begin
          fails++;
          $display("FAIL halt_state: halted=%b pc=%h req/en=%b expected 1 %h 0",
                   halted, pc, {imem_req, alu_en, dmem_req, rf_we}, exp_pc);
        end
        start = ~start;
        @(negedge clk);
      end
      start = 1'b0;
      return;
    end
    tests++;
    if (alu_en !== 1'b1 || alu_op_q !== c.aop || alu_src_q !== c.asrc || wb_sel !== c.m2r) begin
      fails++;
      $display("FAIL exec_phase: alu_en=%b aop=%h asrc=%b wb_sel=%h expected 1 %h %b %h",
               alu_en, alu_op_q, alu_src_q, wb_sel, c.aop, c.asrc, c.m2r);
    end
    @(negedge clk);
    cond_true = ~cnd; branch_target = ~tgt;
    if (c.mr || c.mw) begin
      for (int unsigned i = 0; i <= mdly; i++) begin
        tests++;
        if (dmem_req !== 1'b1 || dmem_we !== c.mw || alu_en !== 1'b0) begin
          fails++;
          $display("FAIL mem_phase: cycle %0d dmem_req=%b dmem_we=%b alu_en=%b expected 1 %b 0",
                   i, dmem_req, dmem_we, alu_en, c.mw);
        end
        dmem_ack = (i == mdly);
        @(negedge clk);
      end
      dmem_ack = 1'b0;
    end
    tests++;
    if (rf_we !== c.rw || wb_sel !== c.m2r || dmem_req !== 1'b0 || alu_en !== 1'b0 || error !== 1'b0) begin
      fails++;
      $display("FAIL wb_phase: rf_we=%b wb_sel=%h dmem_req=%b alu_en=%b err=%b expected %b %h 0 0 0",
               rf_we, wb_sel, dmem_req, alu_en, error, c.rw, c.m2r);
    end
    if (c.br == 2'b10 || c.br == 2'b11 || (c.br == 2'b01 && cnd)) exp_pc = tgt;
    else exp_pc = exp_pc + 32'd4;
    @(negedge clk);
    tests++;
    if (pc !== exp_pc || imem_req !== 1'b1 || rf_we !== 2'b00) begin
      fails++;
      $display("FAIL pc_update: op=%h pc=%h imem_req=%b rf_we=%b expected pc=%h req=1 rf_we=00",
               op, pc, imem_req, rf_we, exp_pc);
    end
  endtask

  task automatic test_alu();
    do_start();
    run_instr(6'b000000, 0, 0, 1'b1, 32'h1234);
    run_instr(6'b000000, 3, 0, 1'b0, 32'h0);
  endtask

  task automatic test_memory();
    run_instr(6'b000101, 0, 2, 1'b0, 32'h0);
    run_instr(6'b000110, 1, 0, 1'b1, 32'h80);
    run_instr(6'b000111, 0, 4, 1'b0, 32'h0);
  endtask

  task automatic test_branch();
    run_instr(6'b000011, 0, 0, 1'b1, 32'h40);
    run_instr(6'b000011, 0, 0, 1'b0, 32'h40);
    run_instr(6'b001001, 0, 0, 1'b0, 32'h100);
    run_instr(6'b001000, 0, 0, 1'b0, 32'hFFFF_FFFC);
    run_instr(6'b000000, 0, 0, 1'b1, 32'h0);
  endtask

  task automatic test_timeout_boundary();
    run_instr(6'b000000, TMO, 0, 1'b0, 32'h0);
    run_instr(6'b000101, 0, TMO, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      run_instr(ops[$urandom_range(6, 0)], $urandom_range(4, 0), $urandom_range(4, 0),
                1'($urandom), $urandom);
  endtask

  task automatic test_halt();
    test_reset();
    do_start();
    run_instr(6'b000000, 0, 0, 1'b0, 32'h0);
    run_instr(6'b000000, 1, 0, 1'b0, 32'h0);
    run_instr(HALT, 0, 0, 1'b1, 32'hDEAD_BEE0);
  endtask

  task automatic test_fetch_timeout();
    test_reset();
    do_start();
    for (int unsigned i = 0; i <= TMO; i++) begin
      tests++;
      if (imem_req !== 1'b1 || error !== 1'b0) begin
        fails++; $display("FAIL fetch_wait: cycle %0d imem_req=%b error=%b expected 1 0", i, imem_req, error);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (error !== 1'b1 || imem_req !== 1'b0 || halted !== 1'b0) begin
        fails++; $display("FAIL fetch_error: error=%b imem_req=%b halted=%b expected 1 0 0", error, imem_req, halted);
      end
      start = ~start;
      @(negedge clk);
    end
    test_reset();
  endtask

  task automatic test_dmem_timeout();
    do_start();
    imem_rdata = {6'b000110, 26'h0}; imem_ack = 1'b1;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int unsigned i = 0; i <= TMO; i++) begin
      tests++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin
        fails++; $display("FAIL dmem_wait: cycle %0d dmem_req=%b dmem_we=%b expected 1 1", i, dmem_req, dmem_we);
      end
      @(negedge clk);
    end
    tests++;
    if (error !== 1'b1 || dmem_req !== 1'b0 || rf_we !== 2'b00 || pc !== 32'h0) begin
      fails++; $display("FAIL dmem_error: error=%b dmem_req=%b rf_we=%b pc=%h expected 1 0 00 0", error, dmem_req, rf_we, pc);
    end
  endtask

  task automatic test_reset_mid_mem();
    test_reset();
    do_start();
    run_instr(6'b000000, 0, 0, 1'b0, 32'h0);
    imem_rdata = {6'b000101, 26'h0}; imem_ack = 1'b1;
    @(negedge clk); imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (dmem_req !== 1'b1) begin
      fails++; $display("FAIL mid_mem_req: dmem_req=%b expected 1", dmem_req);
    end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (dmem_req !== 1'b0 || pc !== 32'h0 || rf_we !== 2'b00) begin
      fails++; $display("FAIL async_abort: dmem_req=%b pc=%h rf_we=%b expected 0 0 00", dmem_req, pc, rf_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = '0;
    @(negedge clk);
    tests++;
    if (imem_req !== 1'b0 || dmem_req !== 1'b0 || pc !== 32'h0) begin
      fails++; $display("FAIL back_to_idle: imem_req=%b dmem_req=%b pc=%h expected 0 0 0", imem_req, dmem_req, pc);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_memory();
    test_branch();
    test_timeout_boundary();
    test_random();
    test_halt();
    test_fetch_timeout();
    test_dmem_timeout();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
